data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
//
// PURPOSE
// Parametrised, byte-addressable RV32 data memory with a valid/ready request
// port and a registered response. Supports sb/sh/sw and lb/lbu/lh/lhu/lw with
// little-endian lanes, misalignment and range checking, and programmable wait
// states. Sits between the execute/memory stage and the data store and stalls
// the core through req_ready / rsp_valid.
//
// PARAMETERS
// DEPTH_BYTES  4096   size of the byte array; power of two, >= 4
// BASE_ADDR    32'h0  first mapped byte address; must be DEPTH_BYTES-aligned
// WAIT_CYCLES  0      extra cycles between accept and response (0..15)
// INIT_FILE    ""     optional $readmemh image; empty string = no preload
//
// PORTS
// clk           in   1   clock, all state updates on the rising edge
// rst           in   1   synchronous reset, active-high
// req_valid     in   1   request present
// req_ready     out  1   controller can accept a request this cycle
// req_write     in   1   1 = store, 0 = load
// req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
// req_unsigned  in   1   loads only: 1 = zero-extend (lbu/lhu)
// req_addr      in   32  byte address
// req_wdata     in   32  store data; bytes taken from the low lanes
// rsp_valid     out  1   one-cycle pulse: response/commit of accepted request
// rsp_rdata     out  32  load result, extended to 32 bits; 0 for stores
// rsp_error     out  1   request was misaligned, out of range or illegal size
//
// BEHAVIOUR
// - FSM states IDLE, WAIT, RESP. Reset: IDLE, req_ready=0 while rst=1,
//   rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter=0. Array not reset.
// - req_ready = 1 only in IDLE (and rst=0). Accept = req_valid & req_ready;
//   accepted write, size, unsigned, addr, wdata are latched; later input
//   changes are ignored.
// - IDLE -> RESP on accept if WAIT_CYCLES=0, else IDLE -> WAIT with counter
//   loaded to WAIT_CYCLES-1; WAIT decrements, -> RESP when counter = 0.
//   RESP -> IDLE unconditionally. Latency accept-edge to rsp_valid:
//   WAIT_CYCLES+1 cycles; throughput one request per WAIT_CYCLES+2 cycles.
// - rsp_valid is high exactly one cycle (in RESP); rsp_rdata/rsp_error hold
//   their values until the next response, rsp_valid drops to 0.
// - Error check on latched request: size=11; half with addr[0]=1; word with
//   addr[1:0]!=0; (addr-BASE_ADDR) >= DEPTH_BYTES or addr < BASE_ADDR.
//   Error: no array write, rsp_rdata=0, rsp_error=1.
// - Store commits on the edge entering RESP: sb writes wdata[7:0] at addr;
//   sh writes [15:0] to addr..addr+1; sw writes [31:0] to addr..addr+3,
//   LSB at lowest address. Untouched bytes keep their value.
// - Load data read from array on the edge entering RESP (array contents
//   before any same-edge write; only one request in flight, so no hazard).
//   lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw unmodified.
// - Index = (addr-BASE_ADDR) truncated to $clog2(DEPTH_BYTES) bits after
//   range check passes; no wrap-around of a multi-byte access is possible
//   because aligned accesses never straddle the top of the array.
// - rst during WAIT/RESP: request abandoned; a store not yet committed is
//   dropped; a store committed on the same edge rst is sampled is also
//   suppressed (rst has priority); no rsp_valid is generated for it.
// - rsp_error on stores has rsp_rdata=0; rsp_rdata=0 for all stores.
//
// TESTING
// 1 WAIT_CYCLES=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_valid 1 cycle
//   after each accept, rdata=0xDEADBEEF, rsp_error=0; req_ready low in RESP.
// 2 After (1): lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE;
//   lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF; sb 0x55 @0x11 then
//   lw @0x10 -> 0xDEAD55EF.
// 3 Misaligned: sw @0x21 and lh @0x23 -> rsp_error=1, rdata=0; subsequent
//   lw @0x20 shows prior contents unchanged; size=11 -> rsp_error=1.
// 4 Range: DEPTH_BYTES=4096, lw @0x1000 -> error; sw @0xFFC then lw @0xFFC
//   -> data returned, no error.
// 5 WAIT_CYCLES=3: rsp_valid exactly 4 cycles after accept; req_valid held
//   high continuously -> accepts spaced 5 cycles; inputs changed mid-WAIT
//   have no effect on result.
// 6 rst asserted in WAIT of a sw 0x12345678 @0x40 -> no rsp_valid, outputs
//   zero next cycle, lw @0x40 returns the pre-store value.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32 data memory behind a valid/ready request port with a
// registered single-cycle response pulse and a fixed number of wait states.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic        go_resp;
  logic        mem_we;
  logic        cur_wr;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] cur_off;
  logic        cur_err;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0] load_val;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

  // While IDLE the request being accepted is used directly, so a zero-wait
  // configuration can resolve it on the accepting edge.
  assign cur_wr    = (state_q == S_IDLE) ? req_write    : wr_q;
  assign cur_size  = (state_q == S_IDLE) ? req_size     : size_q;
  assign cur_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;
  assign cur_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;
  assign cur_off   = cur_addr - BASE_ADDR;

  assign idx0 = cur_off[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

  always_comb begin
    cur_err = 1'b0;
    case (cur_size)
      2'b01:   cur_err = cur_addr[0];
      2'b10:   cur_err = |cur_addr[1:0];
      2'b11:   cur_err = 1'b1;
      default: cur_err = 1'b0;
    endcase
    if ((cur_addr < BASE_ADDR) || (cur_off >= 32'(DEPTH_BYTES))) begin
      cur_err = 1'b1;
    end
  end

  always_comb begin
    load_val = '0;
    case (cur_size)
      2'b00:   load_val = {{24{~cur_uns & mem[idx0][7]}}, mem[idx0]};
      2'b01:   load_val = {{16{~cur_uns & mem[idx1][7]}}, mem[idx1], mem[idx0]};
      default: load_val = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    go_resp = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          go_resp = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (go_resp) begin
      state_d = S_RESP;
      err_d   = cur_err;
      rdata_d = (cur_wr || cur_err) ? 32'h0 : load_val;
      mem_we  = cur_wr && !cur_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset wins over a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[idx0] <= cur_wdata[7:0];
      if (cur_size != 2'b00) begin
        mem[idx1] <= cur_wdata[15:8];
      end
      if (cur_size == 2'b10) begin
        mem[idx2] <= cur_wdata[23:16];
        mem[idx3] <= cur_wdata[31:24];
      end
    end
  end

endmodule
